cpu_datapath: RTL and testbench

//  32-bit single-bus CPU datapath: 16 GPRs, PC, IR, MAR, MDR, Y, HI, LO, 64-bit Z and ALU on one bus.

---
 rtl/cpu_datapath.sv | 163 ++++++++++++++++
 tb/tb_cpu_datapath.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: 16 GPRs, PC, IR, MAR, MDR, Y, HI, LO, 64-bit Z and a combinational ALU.
// Latency: bus and ALU are combinational; every load lands on the rising edge where its strobe is high.
// Backpressure: none; the controller sequences every transfer with per-register in/out strobes.
module cpu_datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] A,
  input  logic [31:0] RegisterImmediate,
  input  logic        Read,
  input  logic [31:0] Mdatain,
  input  logic [3:0]  ALUop,
  input  logic [15:0] Rin,
  input  logic [15:0] Rout,
  input  logic        MARin,
  output logic [31:0] MARout,
  input  logic        PCin,
  input  logic        PCout,
  input  logic        IRin,
  input  logic        IRout,
  input  logic        Yin,
  input  logic        Yout,
  input  logic        MDRin,
  input  logic        MDRout,
  input  logic        HIin,
  input  logic        HIout,
  input  logic        LOin,
  input  logic        LOout,
  input  logic        Zhighin,
  input  logic        Zlowin,
  input  logic        Zhighout,
  input  logic        Zlowout
);

  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [31:0] y_q, y_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] z_q, z_d;

  logic [31:0] bus;
  logic        bus_hit;
  logic [31:0] res_lo, res_hi;
  logic [63:0] prod, rot_r, rot_l;
  logic [4:0]  sh;

  // Reserved inputs have no function in this revision.
  logic unused_inputs;
  assign unused_inputs = ^{A, RegisterImmediate};

  assign MARout = mar_q;

  // Bus source mux: fixed-priority if-chain so an unknown select never wins the bus.
  always_comb begin
    bus     = 32'h0;
    bus_hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!bus_hit && Rout[i]) begin
        bus     = r_q[i];
        bus_hit = 1'b1;
      end
    end
    if (!bus_hit) begin
      if (HIout)         bus = hi_q;
      else if (LOout)    bus = lo_q;
      else if (Zhighout) bus = z_q[63:32];
      else if (Zlowout)  bus = z_q[31:0];
      else if (PCout)    bus = pc_q;
      else if (MDRout)   bus = mdr_q;
      else if (Yout)     bus = y_q;
      else if (IRout)    bus = ir_q;
    end
  end

  // ALU: a = Y, b = bus; rotates use a doubled operand so a zero amount is naturally a no-op.
  assign sh    = bus[4:0];
  assign prod  = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
  assign rot_r = {y_q, y_q} >> sh;
  assign rot_l = {y_q, y_q} << sh;

  always_comb begin
    res_lo = bus;
    res_hi = 32'h0;
    case (ALUop)
      4'd0:  res_lo = y_q + bus;
      4'd1:  res_lo = y_q - bus;
      4'd2:  res_lo = y_q & bus;
      4'd3:  res_lo = y_q | bus;
      4'd4:  res_lo = y_q >> sh;
      4'd5:  res_lo = $signed(y_q) >>> sh;
      4'd6:  res_lo = y_q << sh;
      4'd7:  res_lo = rot_r[31:0];
      4'd8:  res_lo = rot_l[63:32];
      4'd9:  begin res_lo = prod[31:0]; res_hi = prod[63:32]; end
      4'd10: res_lo = 32'h0 - bus;
      4'd11: res_lo = ~bus;
      4'd12: begin
        if (bus == 32'h0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = y_q;
        end else begin
          res_lo = $signed(y_q) / $signed(bus);
          res_hi = $signed(y_q) % $signed(bus);
        end
      end
      4'd13: res_lo = bus + 32'h1;
      default: res_lo = bus;
    endcase
  end

  // Next-state: each sink takes the bus (or ALU / memory data) when its strobe is high.
  always_comb begin
    for (int i = 0; i < 16; i++) r_d[i] = r_q[i];
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    z_d   = z_q;
    for (int i = 0; i < 16; i++) begin
      if (Rin[i]) r_d[i] = bus;
    end
    if (PCin)  pc_d  = bus;
    if (IRin)  ir_d  = bus;
    if (MARin) mar_d = bus;
    if (Yin)   y_d   = bus;
    if (HIin)  hi_d  = bus;
    if (LOin)  lo_d  = bus;
    if (MDRin) begin
      if (Read) mdr_d = Mdatain;
      else      mdr_d = bus;
    end
    if (Zhighin) z_d[63:32] = res_hi;
    if (Zlowin)  z_d[31:0]  = res_lo;
  end

  // State registers: clear wins over every load strobe.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= 32'h0;
      pc_q  <= 32'h0;
      ir_q  <= 32'h0;
      mar_q <= 32'h0;
      mdr_q <= 32'h0;
      y_q   <= 32'h0;
      hi_q  <= 32'h0;
      lo_q  <= 32'h0;
      z_q   <= 64'h0;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      z_q   <= z_d;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed sequences plus randomized ALU and bus-priority checks.
// Latency: each transfer is one clock; outputs and probed registers are sampled 1 time unit after the edge.
// Backpressure: none; the bench drives the strobes directly.
module tb_cpu_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] A, RegisterImmediate;
  logic        Read;
  logic [31:0] Mdatain;
  logic [3:0]  ALUop;
  logic [15:0] Rin, Rout;
  logic        MARin;
  logic [31:0] MARout;
  logic        PCin, PCout, IRin, IRout, Yin, Yout, MDRin, MDRout;
  logic        HIin, HIout, LOin, LOout, Zhighin, Zlowin, Zhighout, Zlowout;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cpu_datapath dut (
    .clock(clock), .clear(clear), .A(A), .RegisterImmediate(RegisterImmediate),
    .Read(Read), .Mdatain(Mdatain), .ALUop(ALUop), .Rin(Rin), .Rout(Rout),
    .MARin(MARin), .MARout(MARout), .PCin(PCin), .PCout(PCout), .IRin(IRin), .IRout(IRout),
    .Yin(Yin), .Yout(Yout), .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .Zhighout(Zhighout), .Zlowout(Zlowout)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Read = 0; ALUop = 0; Rin = 0; Rout = 0; MARin = 0;
    PCin = 0; PCout = 0; IRin = 0; IRout = 0; Yin = 0; Yout = 0; MDRin = 0; MDRout = 0;
    HIin = 0; HIout = 0; LOin = 0; LOout = 0; Zhighin = 0; Zlowin = 0; Zhighout = 0; Zlowout = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1; tick();
  endtask

  task automatic set_reg(input int k, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Rin[k] = 1'b1; tick();
  endtask

  task automatic set_y(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; Yin = 1; tick();
  endtask

  // Reference ALU from the operation definitions, using plain arithmetic and bit loops.
  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          s;
    logic [31:0] lo, hi;
    logic [63:0] pw;
    longint      q, r, p;
    s  = int'(b[4:0]);
    pw = 64'd1 << s;
    lo = 32'h0;
    hi = 32'h0;
    case (op)
      4'd0:  lo = a + b;
      4'd1:  lo = a - b;
      4'd2:  lo = a & b;
      4'd3:  lo = a | b;
      4'd4:  lo = 32'({32'h0, a} / pw);
      4'd5:  lo = a[31] ? ~(32'({32'h0, ~a} / pw)) : 32'({32'h0, a} / pw);
      4'd6:  lo = 32'({32'h0, a} * pw);
      4'd7:  for (int i = 0; i < 32; i++) lo[i] = a[(i + s) % 32];
      4'd8:  for (int i = 0; i < 32; i++) lo[(i + s) % 32] = a[i];
      4'd9:  begin
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        hi = p[63:32];
      end
      4'd10: lo = 32'h0 - b;
      4'd11: lo = ~b;
      4'd12: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          q  = longint'($signed(a)) / longint'($signed(b));
          r  = longint'($signed(a)) - q * longint'($signed(b));
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      4'd13: lo = b + 32'h1;
      default: lo = b;
    endcase
    return {hi, lo};
  endfunction

  // Run one ALU op with Y=a, bus=b (from R1), capture both Z halves into R2/R3.
  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    exp = alu_ref(op, a, b);
    set_y(a);
    set_reg(1, b);
    Rout[1] = 1'b1; ALUop = op; Zhighin = 1; Zlowin = 1; tick();
    check_val({tag, "_z"}, dut.z_q, exp);
    Zhighout = 1; Rin[2] = 1'b1; tick();
    Zlowout = 1; Rin[3] = 1'b1; tick();
    check_val({tag, "_bus"}, {dut.r_q[2], dut.r_q[3]}, exp);
  endtask

  logic [31:0] src_val [24];

  task automatic drive_src(input logic [23:0] m);
    Rout = m[15:0]; HIout = m[16]; LOout = m[17]; Zhighout = m[18]; Zlowout = m[19];
    PCout = m[20]; MDRout = m[21]; Yout = m[22]; IRout = m[23];
  endtask

  initial begin
    logic [63:0] zexp;
    logic [31:0] a, b, exp_bus;
    logic [23:0] m;
    logic [3:0]  op;
    A = 0; RegisterImmediate = 0; Mdatain = 0;
    idle();
    clear = 1;
    tick(); tick();
    clear = 0;

    // Reset state
    check_val("rst_r0", dut.r_q[0], 0);
    check_val("rst_r15", dut.r_q[15], 0);
    check_val("rst_pc_ir", {dut.pc_q, dut.ir_q}, 0);
    check_val("rst_mar", MARout, 0);
    check_val("rst_mdr_y", {dut.mdr_q, dut.y_q}, 0);
    check_val("rst_hi_lo", {dut.hi_q, dut.lo_q}, 0);
    check_val("rst_z", dut.z_q, 0);

    // Clear mid-sequence
    set_reg(3, 32'h1234);
    check_val("r3_loaded", dut.r_q[3], 32'h1234);
    load_mdr(32'h40); MDRout = 1; PCin = 1; MARin = 1; tick();
    Zlowin = 1; Rout[3] = 1'b1; ALUop = 4'd13; tick();
    clear = 1; Rin = 16'hFFFF; PCin = 1; MDRin = 1; Read = 1; Mdatain = 32'hDEAD; @(posedge clock); #1; idle();
    clear = 0;
    check_val("clr_r3", dut.r_q[3], 0);
    check_val("clr_pc_mdr", {dut.pc_q, dut.mdr_q}, 0);
    check_val("clr_z", dut.z_q, 0);
    check_val("clr_mar", MARout, 0);

    // NEG
    load_mdr(32'h5);
    MDRout = 1; Rin[7] = 1'b1; tick();
    Rout[7] = 1'b1; ALUop = 4'd10; Zlowin = 1; tick();
    Zlowout = 1; Rin[4] = 1'b1; tick();
    check_val("neg_r7", dut.r_q[7], 32'h5);
    check_val("neg_r4", dut.r_q[4], 32'hFFFF_FFFB);

    // Fetch with PC increment
    load_mdr(32'h10); MDRout = 1; PCin = 1; tick();
    PCout = 1; MARin = 1; Zlowin = 1; ALUop = 4'd13; tick();
    Zlowout = 1; PCin = 1; tick();
    check_val("fetch_mar", MARout, 32'h10);
    check_val("fetch_pc", dut.pc_q, 32'h11);

    // MUL into HI/LO
    set_y(32'hFFFF_FFFE);
    set_reg(1, 32'h3);
    Rout[1] = 1'b1; ALUop = 4'd9; Zhighin = 1; Zlowin = 1; tick();
    Zhighout = 1; HIin = 1; tick();
    Zlowout = 1; LOin = 1; tick();
    check_val("mul_hi", dut.hi_q, 32'hFFFF_FFFF);
    check_val("mul_lo", dut.lo_q, 32'hFFFF_FFFA);

    // DIV and divide-by-zero
    set_y(32'd7); set_reg(1, 32'd2);
    Rout[1] = 1'b1; ALUop = 4'd12; Zhighin = 1; Zlowin = 1; tick();
    check_val("div_7_2", dut.z_q, {32'd1, 32'd3});
    set_reg(1, 32'd0);
    Rout[1] = 1'b1; ALUop = 4'd12; Zhighin = 1; Zlowin = 1; tick();
    check_val("div_7_0", dut.z_q, {32'd7, 32'hFFFF_FFFF});

    // Shifts and rotates by zero return a
    for (int k = 4; k <= 8; k++) run_alu($sformatf("sh0_op%0d", k), 4'(k), 32'h8123_4567, 32'h0000_0020);

    // Idle bus loads zero
    set_reg(2, 32'hABCD);
    Rin[2] = 1'b1; tick();
    check_val("idle_bus", dut.r_q[2], 0);

    // Same register driven and loaded: others see the old value, it keeps it
    set_reg(6, 32'h6666);
    Rout[6] = 1'b1; Rin[6] = 1'b1; Rin[10] = 1'b1; tick();
    check_val("self_r6_r10", {dut.r_q[6], dut.r_q[10]}, {32'h6666, 32'h6666});

    // Randomized ALU ops
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (op == 4'd12 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
      run_alu($sformatf("alu%0d_op%0d", n, op), op, a, b);
    end

    // Bus priority with every source holding a distinct value
    for (int k = 0; k < 16; k++) begin
      src_val[k] = $urandom;
      set_reg(k, src_val[k]);
    end
    src_val[16] = $urandom; load_mdr(src_val[16]); MDRout = 1; HIin = 1; tick();
    src_val[17] = $urandom; load_mdr(src_val[17]); MDRout = 1; LOin = 1; tick();
    src_val[20] = $urandom; load_mdr(src_val[20]); MDRout = 1; PCin = 1; tick();
    src_val[23] = $urandom; load_mdr(src_val[23]); MDRout = 1; IRin = 1; tick();
    src_val[22] = $urandom; set_y(src_val[22]);
    zexp = alu_ref(4'd9, src_val[22], src_val[0]);
    Rout[0] = 1'b1; ALUop = 4'd9; Zhighin = 1; Zlowin = 1; tick();
    src_val[18] = zexp[63:32];
    src_val[19] = zexp[31:0];
    src_val[21] = $urandom; load_mdr(src_val[21]);
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       m = 24'h0;
        1:       m = 24'(1) << $urandom_range(0, 23);
        2:       m = (24'(1) << $urandom_range(16, 23)) | ((24'(1) << $urandom_range(16, 23)));
        default: m = 24'($urandom & $urandom);
      endcase
      exp_bus = 32'h0;
      for (int k = 23; k >= 0; k--) if (m[k]) exp_bus = src_val[k];
      drive_src(m); MARin = 1; tick();
      check_val($sformatf("prio%0d_m%06h", n, m), MARout, exp_bus);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
